// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//
// Shared definitions for the two-port memory arbiter:
//   - default address/data widths of the attached single-port memory
//   - FSM state encodings (kept as plain 2-bit constants so the values stay
//     stable for anything that decodes them outside this slice)
//   - port_t, the index of a requester, used for the grant and the
//     round-robin pointer
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  // The port that did not win last time; used to break a tie.
  function automatic port_t other_port(input port_t p);
    return (p == PORT1) ? PORT0 : PORT1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles every bus signal around the arbiter: the two requester ports and
// the memory-side address/data/we/read-data path.
//
//   Requester side (per port n = 0,1):
//     reqn    request, held until donen
//     addrn   request address (AW)
//     wdatan  write data (DW)
//     wen     1 = write, 0 = read
//     donen   one-cycle completion pulse
//     rdatan  read data, valid while donen is high
//   Memory side:
//     mem_addr, mem_wdata, mem_we   driven by the arbiter only
//     mem_rdata                     registered read data from the memory
//
// Modports:
//   slave  : the arbiter's view
//   master : the clients' + memory's view (used by a bench or the top wrapper)
// -----------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
);

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          we0;
  logic          we1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    input  mem_rdata,
    output done0, done1, rdata0, rdata1,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    output mem_rdata,
    input  done0, done1, rdata0, rdata1,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Purely combinational two-way round-robin picker.
//
// Ports:
//   req0, req1   input   requests
//   last         input   port granted most recently
//   grant_valid  output  at least one request is present
//   grant_idx    output  winning port
//
// A lone request always wins. When both are present, the port that was not
// granted last time wins.
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last,
  output logic  grant_valid,
  output port_t grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT0;
    if (req0 && req1) begin
      grant_idx = other_port(last);
    end else if (req1) begin
      grant_idx = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between two requesters with
// round-robin fairness. Each granted access walks a fixed sequence:
//   IDLE    -> pick winner, latch its addr/wdata/we and the grant index
//   ACCESS  -> latched address/wdata on the memory, mem_we = latched we
//   CAPTURE -> mem_we low, memory read data registered into the winner's rdata
//   DONE    -> winner's done pulses for one cycle, requests ignored
// giving one access every four cycles.
//
// Ports:
//   clk    input  single clock, posedge
//   reset  input  synchronous, active-high; overrides every transition
//   bus    slave modport of mem_arbiter_if (requester ports + memory path)
//
// The memory returns read data one cycle after the address is presented and
// commits a write on the edge that ends the mem_we cycle, so a reset sampled
// in ACCESS still lets that write land; no done is issued afterwards.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
)(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_t        state;
  port_t         last;
  port_t         gidx;

  logic          grant_valid;
  port_t         grant_idx;

  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic          done0_q;
  logic          done1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  rr_arb2 u_rr_arb2 (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last        <= PORT1;
      gidx        <= PORT0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        // IDLE -> ACCESS: the memory-side registers double as the request
        // latch, so addr/wdata/we are frozen here until the next grant.
        ST_IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (grant_valid) begin
            gidx <= grant_idx;
            last <= grant_idx;
            if (grant_idx == PORT1) begin
              mem_addr_q  <= bus.addr1;
              mem_wdata_q <= bus.wdata1;
              mem_we_q    <= bus.we1;
            end else begin
              mem_addr_q  <= bus.addr0;
              mem_wdata_q <= bus.wdata0;
              mem_we_q    <= bus.we0;
            end
            state <= ST_ACCESS;
          end
        end

        // ACCESS -> CAPTURE: write (if any) commits on this edge.
        ST_ACCESS: begin
          mem_we_q <= 1'b0;
          state    <= ST_CAPTURE;
        end

        // CAPTURE -> DONE: read data for the ACCESS address is on mem_rdata.
        ST_CAPTURE: begin
          mem_we_q <= 1'b0;
          if (gidx == PORT1) begin
            rdata1_q <= bus.mem_rdata;
            done1_q  <= 1'b1;
          end else begin
            rdata0_q <= bus.mem_rdata;
            done0_q  <= 1'b1;
          end
          state <= ST_DONE;
        end

        // DONE -> IDLE: requests are not looked at in this cycle.
        ST_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          mem_we_q <= 1'b0;
          done0_q  <= 1'b0;
          done1_q  <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule
